// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and constants for the instruction-memory arbiter
package imem_pkg;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_LOAD  = 1'b1
  } req_id_e;

  // Returned on a rejected fetch so a core that ignores fetch_err executes a no-op
  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter, combinational grant, registered pointer
module rr_arb2
  import imem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  req_id_e prio_q, prio_d;

  always_comb begin
    gnt_o  = 2'b00;
    prio_d = prio_q;
    if (req_i == 2'b11) begin
      gnt_o = (prio_q == REQ_FETCH) ? 2'b01 : 2'b10;
    end else begin
      gnt_o = req_i;
    end
    // The winner yields priority to the other requester
    if (gnt_o[0]) begin
      prio_d = REQ_LOAD;
    end else if (gnt_o[1]) begin
      prio_d = REQ_FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q <= REQ_FETCH;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - arbitrates core fetch and boot loader onto a single-port instruction memory
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [XLEN-1:0]       fetch_addr,
  output logic                  fetch_gnt,
  output logic                  fetch_rvalid,
  output logic [31:0]           fetch_rdata,
  output logic                  fetch_err,
  input  logic                  load_req,
  input  logic [XLEN-1:0]       load_addr,
  input  logic [31:0]           load_wdata,
  output logic                  load_gnt,
  input  logic                  load_done,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic                  running,
  output logic [15:0]           conflict_cnt
);

  state_e      state_q, state_d;
  logic        fetch_act, load_act;
  logic [1:0]  gnt;
  logic        fetch_ok, load_ok;
  logic        rvalid_q, err_q;
  logic [15:0] cnt_q;

  function automatic logic addr_ok(input logic [XLEN-1:0] addr);
    return (addr[1:0] == 2'b00) && ((addr >> (ADDR_WIDTH + 2)) == '0);
  endfunction

  assign running   = (state_q == RUN);
  // Nothing is granted while reset is held so no access straddles it
  assign fetch_act = fetch_req && running && !reset;
  assign load_act  = load_req && !reset;
  assign fetch_ok  = addr_ok(fetch_addr);
  assign load_ok   = addr_ok(load_addr);

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req_i ({load_act, fetch_act}),
    .gnt_o (gnt)
  );

  assign fetch_gnt = gnt[0];
  assign load_gnt  = gnt[1];

  always_comb begin
    state_d = state_q;
    if (state_q == BOOT && load_done) begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (load_gnt) begin
      mem_en    = load_ok;
      mem_we    = load_ok;
      mem_addr  = load_addr[ADDR_WIDTH+1:2];
      mem_wdata = load_wdata;
    end else if (fetch_gnt) begin
      mem_en    = fetch_ok;
      mem_addr  = fetch_addr[ADDR_WIDTH+1:2];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      rvalid_q <= fetch_gnt;
      err_q    <= fetch_gnt && !fetch_ok;
      if (fetch_act && load_act && cnt_q != 16'hFFFF) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  // A response due in a reset cycle belongs to a grant from before the reset
  assign fetch_rvalid = rvalid_q && !reset;
  assign fetch_err    = fetch_rvalid && err_q;
  assign fetch_rdata  = !fetch_rvalid ? 32'h0 : (err_q ? NOP : mem_rdata);
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - self-checking bench for imem_arbiter
module tb_imem_arbiter;

  localparam int AW = 8;
  localparam logic [31:0] NOP_W = 32'h0000_0013;

  logic          clk, reset;
  logic          fetch_req, fetch_gnt, fetch_rvalid, fetch_err;
  logic [31:0]   fetch_addr, fetch_rdata;
  logic          load_req, load_gnt, load_done;
  logic [31:0]   load_addr, load_wdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic          running;
  logic [15:0]   conflict_cnt;

  int n_vec = 0;
  int n_err = 0;

  imem_arbiter #(.XLEN(32), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata), .fetch_err(fetch_err),
    .load_req(load_req), .load_addr(load_addr), .load_wdata(load_wdata),
    .load_gnt(load_gnt), .load_done(load_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .running(running), .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment memory driven by the DUT
  logic [31:0] ram [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  // Reference model state
  bit          m_run, m_fav_fetch, m_rv, m_rerr;
  int          m_cnt;
  logic [31:0] m_rdata;
  logic [31:0] shadow [256];
  // Expectations for the current cycle
  bit          e_gf, e_gl, e_en, e_we, e_rv, e_err;
  logic [7:0]  e_addr;
  logic [31:0] e_wdata, e_rdata;

  function automatic bit addr_ok(input logic [31:0] a);
    return (a % 4 == 0) && (a < (32'd4 << AW));
  endfunction

  task automatic apply(input bit r, input bit fr, input logic [31:0] fad,
                       input bit lr, input logic [31:0] lad, input logic [31:0] lwd,
                       input bit ld);
    bit fa, la;
    @(negedge clk);
    reset = r; fetch_req = fr; fetch_addr = fad;
    load_req = lr; load_addr = lad; load_wdata = lwd; load_done = ld;
    fa = fr && m_run && !r;
    la = lr && !r;
    if (fa && la) begin
      e_gf = m_fav_fetch; e_gl = !m_fav_fetch;
    end else begin
      e_gf = fa; e_gl = la;
    end
    e_en = 0; e_we = 0; e_addr = 0; e_wdata = 0;
    if (e_gl) begin
      e_en = addr_ok(lad); e_we = e_en; e_addr = 8'((lad / 4) % 256); e_wdata = lwd;
    end else if (e_gf) begin
      e_en = addr_ok(fad); e_addr = 8'((fad / 4) % 256);
    end
    e_rv    = m_rv && !r;
    e_err   = e_rv && m_rerr;
    e_rdata = e_rv ? m_rdata : 32'h0;
    #1;
  endtask

  task automatic advance();
    @(posedge clk);
    if (reset) begin
      m_run = 0; m_fav_fetch = 1; m_cnt = 0; m_rv = 0; m_rerr = 0;
    end else begin
      m_rv    = e_gf;
      m_rerr  = e_gf && !addr_ok(fetch_addr);
      m_rdata = m_rerr ? NOP_W : shadow[(fetch_addr / 4) % 256];
      if (e_gl && addr_ok(load_addr)) shadow[load_addr / 4] = load_wdata;
      if (e_gf) m_fav_fetch = 0;
      if (e_gl) m_fav_fetch = 1;
      if (fetch_req && m_run && load_req && m_cnt < 65535) m_cnt++;
      if (!m_run && load_done) m_run = 1;
    end
  endtask

  task automatic test_reset();
    apply(1, 0, 0, 0, 0, 0, 0); advance();
    apply(0, 0, 0, 0, 0, 0, 0);
    n_vec++; if (running !== 1'b0) begin n_err++; $display("FAIL reset_running: got %b want 0", running); end
    n_vec++; if (fetch_rvalid !== 1'b0 || fetch_err !== 1'b0) begin n_err++; $display("FAIL reset_resp: rvalid %b err %b want 0 0", fetch_rvalid, fetch_err); end
    n_vec++; if (fetch_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", fetch_rdata); end
    n_vec++; if (conflict_cnt !== 16'h0) begin n_err++; $display("FAIL reset_cnt: got %h want 0", conflict_cnt); end
    n_vec++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin n_err++; $display("FAIL reset_mem: en %b we %b want 0 0", mem_en, mem_we); end
    advance();
  endtask

  task automatic test_boot_blocks_fetch();
    for (int i = 0; i < 10; i++) begin
      apply(0, 1, 32'h0, 0, 0, 0, 0);
      n_vec++; if (fetch_gnt !== 1'b0 || running !== 1'b0) begin n_err++; $display("FAIL boot_fetch[%0d]: gnt %b running %b want 0 0", i, fetch_gnt, running); end
      advance();
    end
    apply(0, 1, 32'h0, 1, 32'h4, 32'h0050_0093, 0);
    n_vec++; if (load_gnt !== 1'b1 || fetch_gnt !== 1'b0) begin n_err++; $display("FAIL boot_load_gnt: load %b fetch %b want 1 0", load_gnt, fetch_gnt); end
    n_vec++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, 8'd1, 32'h0050_0093}) begin n_err++; $display("FAIL boot_load_mem: en %b we %b addr %h wdata %h want 1 1 01 00500093", mem_en, mem_we, mem_addr, mem_wdata); end
    advance();
  endtask

  task automatic test_load_and_fetch();
    apply(0, 0, 0, 1, 32'h8, 32'h00A0_0113, 1);
    n_vec++; if (load_gnt !== 1'b1 || running !== 1'b0) begin n_err++; $display("FAIL done_with_load: gnt %b running %b want 1 0", load_gnt, running); end
    advance();
    apply(0, 1, 32'h4, 0, 0, 0, 0);
    n_vec++; if (running !== 1'b1 || fetch_gnt !== 1'b1) begin n_err++; $display("FAIL run_fetch_gnt: running %b gnt %b want 1 1", running, fetch_gnt); end
    n_vec++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'd1) begin n_err++; $display("FAIL run_fetch_mem: en %b we %b addr %h want 1 0 01", mem_en, mem_we, mem_addr); end
    advance();
    apply(0, 0, 0, 0, 0, 0, 0);
    n_vec++; if ({fetch_rvalid, fetch_err, fetch_rdata} !== {2'b10, 32'h0050_0093}) begin n_err++; $display("FAIL run_fetch_resp: rvalid %b err %b rdata %h want 1 0 00500093", fetch_rvalid, fetch_err, fetch_rdata); end
    advance();
  endtask

  task automatic test_round_robin();
    apply(0, 0, 0, 1, 32'h0, 32'h1111_1111, 0);
    advance();
    for (int i = 0; i < 4; i++) begin
      apply(0, 1, 32'h8, 1, 32'h10, 32'hCAFE_0000 + i, 0);
      n_vec++; if ({fetch_gnt, load_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL rr_grant[%0d]: fetch %b load %b want %0s", i, fetch_gnt, load_gnt, (i % 2 == 0) ? "fetch" : "load"); end
      advance();
    end
    apply(0, 0, 0, 0, 0, 0, 0);
    n_vec++; if (conflict_cnt !== 16'd4) begin n_err++; $display("FAIL rr_conflict_cnt: got %0d want 4", conflict_cnt); end
    advance();
  endtask

  task automatic test_invalid_addr();
    apply(0, 1, 32'h2, 0, 0, 0, 0);
    n_vec++; if (fetch_gnt !== 1'b1 || mem_en !== 1'b0) begin n_err++; $display("FAIL misalign_mem: gnt %b en %b want 1 0", fetch_gnt, mem_en); end
    advance();
    apply(0, 1, 32'h400, 0, 0, 0, 0);
    n_vec++; if ({fetch_rvalid, fetch_err, fetch_rdata} !== {2'b11, NOP_W}) begin n_err++; $display("FAIL misalign_resp: rvalid %b err %b rdata %h want 1 1 00000013", fetch_rvalid, fetch_err, fetch_rdata); end
    n_vec++; if (fetch_gnt !== 1'b1 || mem_en !== 1'b0) begin n_err++; $display("FAIL range_mem: gnt %b en %b want 1 0", fetch_gnt, mem_en); end
    advance();
    apply(0, 0, 0, 0, 0, 0, 0);
    n_vec++; if ({fetch_rvalid, fetch_err, fetch_rdata} !== {2'b11, NOP_W}) begin n_err++; $display("FAIL range_resp: rvalid %b err %b rdata %h want 1 1 00000013", fetch_rvalid, fetch_err, fetch_rdata); end
    advance();
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [3];
    words[0] = 32'h1111_1111; words[1] = 32'h0050_0093; words[2] = 32'h00A0_0113;
    for (int i = 0; i < 4; i++) begin
      apply(0, i < 3, 32'(4 * i), 0, 0, 0, 0);
      if (i > 0) begin
        n_vec++; if ({fetch_rvalid, fetch_err, fetch_rdata} !== {2'b10, words[i-1]}) begin n_err++; $display("FAIL b2b_resp[%0d]: rvalid %b err %b rdata %h want 1 0 %h", i - 1, fetch_rvalid, fetch_err, fetch_rdata, words[i-1]); end
      end
      advance();
    end
  endtask

  task automatic test_reset_drops();
    apply(0, 1, 32'h4, 0, 0, 0, 0);
    advance();
    apply(1, 0, 0, 0, 0, 0, 0);
    n_vec++; if (fetch_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_drop_now: rvalid %b want 0", fetch_rvalid); end
    advance();
    apply(0, 1, 32'h4, 0, 0, 0, 0);
    n_vec++; if (fetch_rvalid !== 1'b0 || running !== 1'b0 || fetch_gnt !== 1'b0) begin n_err++; $display("FAIL rst_drop_after: rvalid %b running %b gnt %b want 0 0 0", fetch_rvalid, running, fetch_gnt); end
    advance();
  endtask

  task automatic test_random();
    logic [31:0] fad, lad;
    for (int i = 0; i < 400; i++) begin
      fad = ($urandom_range(0, 7) == 0) ? $urandom() : {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      lad = ($urandom_range(0, 7) == 0) ? $urandom() : {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      apply($urandom_range(0, 79) == 0, $urandom_range(0, 2) != 0, fad,
            $urandom_range(0, 2) == 0, lad, $urandom(), $urandom_range(0, 15) == 0);
      n_vec++; if (fetch_gnt !== e_gf || load_gnt !== e_gl) begin n_err++; $display("FAIL rnd_gnt[%0d]: fetch %b load %b want %b %b", i, fetch_gnt, load_gnt, e_gf, e_gl); end
      n_vec++; if (mem_en !== e_en || mem_we !== e_we) begin n_err++; $display("FAIL rnd_mem_ctl[%0d]: en %b we %b want %b %b", i, mem_en, mem_we, e_en, e_we); end
      if (e_en) begin
        n_vec++; if (mem_addr !== e_addr) begin n_err++; $display("FAIL rnd_mem_addr[%0d]: got %h want %h", i, mem_addr, e_addr); end
      end
      if (e_we) begin
        n_vec++; if (mem_wdata !== e_wdata) begin n_err++; $display("FAIL rnd_mem_wdata[%0d]: got %h want %h", i, mem_wdata, e_wdata); end
      end
      n_vec++; if (fetch_rvalid !== e_rv || fetch_err !== e_err || fetch_rdata !== e_rdata) begin n_err++; $display("FAIL rnd_resp[%0d]: rvalid %b err %b rdata %h want %b %b %h", i, fetch_rvalid, fetch_err, fetch_rdata, e_rv, e_err, e_rdata); end
      n_vec++; if (running !== m_run || conflict_cnt !== 16'(m_cnt)) begin n_err++; $display("FAIL rnd_state[%0d]: running %b cnt %0d want %b %0d", i, running, conflict_cnt, m_run, m_cnt); end
      advance();
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = 32'h0;
      shadow[i] = 32'h0;
    end
    mem_rdata = 32'h0;
    reset = 1; fetch_req = 0; fetch_addr = 0; load_req = 0;
    load_addr = 0; load_wdata = 0; load_done = 0;
    m_run = 0; m_fav_fetch = 1; m_cnt = 0; m_rv = 0; m_rerr = 0; m_rdata = 0;
    test_reset();
    test_boot_blocks_fetch();
    test_load_and_fetch();
    test_round_robin();
    test_invalid_addr();
    test_back_to_back();
    test_reset_drops();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
